// File: rtl/cmos_timing_monitor.sv
// Pixel-clock-domain camera timing monitor: heartbeat, frame-rate window and
// per-frame geometry measurement with sticky error flags for debug/status.
module cmos_timing_monitor #(
  parameter int unsigned HALF_PERIOD = 21_000_000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned LINE_W      = 12,
  parameter int unsigned BYTE_W      = 13,
  parameter int unsigned EXP_LINES   = 720,
  parameter int unsigned EXP_BYTES   = 2560
) (
  input  logic              cmos_pclk,
  input  logic              I_rst_n,
  input  logic              cmos_vsync,
  input  logic              cmos_href,
  input  logic              I_clr,
  output logic              O_heartbeat,
  output logic [7:0]        O_fps,
  output logic [15:0]       O_frame_cnt,
  output logic [LINE_W-1:0] O_lines,
  output logic [BYTE_W-1:0] O_line_bytes,
  output logic [CNT_W-1:0]  O_frame_pclks,
  output logic              O_geom_ok,
  output logic              O_stat_valid,
  output logic [3:0]        O_err
);

  localparam logic [CNT_W-1:0]  HB_LAST   = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(2 * HALF_PERIOD - 1);
  localparam logic [LINE_W-1:0] LINES_EXP = LINE_W'(EXP_LINES);
  localparam logic [BYTE_W-1:0] BYTES_EXP = BYTE_W'(EXP_BYTES);

  // Input sampling and edge-detect pipeline
  logic vs_q, vs_q2, hs_q, hs_q2, fs_q;
  logic frame_start, line_end;

  // Heartbeat and rate window
  logic [CNT_W-1:0]  hb_cnt_q, hb_cnt_d;
  logic              hb_q, hb_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic [7:0]        fr_acc_q, fr_acc_d, fr_inc;
  logic [7:0]        fps_q, fps_d;

  // Per-frame measurement
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [BYTE_W-1:0] first_len_q, first_len_d;
  logic              mism_q, mism_d;
  logic [CNT_W-1:0]  pclk_cnt_q, pclk_cnt_d;
  logic              armed_q, armed_d;

  // Published status
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [LINE_W-1:0] lines_q, lines_d;
  logic [BYTE_W-1:0] line_bytes_q, line_bytes_d;
  logic [CNT_W-1:0]  frame_pclks_q, frame_pclks_d;
  logic              geom_ok_q, geom_ok_d;
  logic              stat_valid_q, stat_valid_d;
  logic [3:0]        err_q, err_d, err_set;

  assign frame_start = vs_q & ~vs_q2;
  assign line_end    = ~hs_q & hs_q2;

  always_comb begin
    // NOTE: every next-state variable takes its held value first so no path
    // through the branches below can infer a latch.
    hb_cnt_d      = hb_cnt_q;
    hb_d          = hb_q;
    win_cnt_d     = win_cnt_q;
    fr_acc_d      = fr_acc_q;
    fps_d         = fps_q;
    byte_cnt_d    = byte_cnt_q;
    line_cnt_d    = line_cnt_q;
    first_len_d   = first_len_q;
    mism_d        = mism_q;
    pclk_cnt_d    = pclk_cnt_q;
    armed_d       = armed_q;
    frame_cnt_d   = frame_cnt_q;
    lines_d       = lines_q;
    line_bytes_d  = line_bytes_q;
    frame_pclks_d = frame_pclks_q;
    geom_ok_d     = geom_ok_q;
    stat_valid_d  = 1'b0;
    err_set       = '0;

    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end else begin
      hb_cnt_d = hb_cnt_q + 1'b1;
    end

    // A frame start landing on the window's last cycle belongs to that window
    fr_inc = (frame_start && (fr_acc_q != 8'hFF)) ? fr_acc_q + 8'd1 : fr_acc_q;
    if (win_cnt_q == WIN_LAST) begin
      win_cnt_d = '0;
      fps_d     = fr_inc;
      fr_acc_d  = '0;
    end else begin
      win_cnt_d = win_cnt_q + 1'b1;
      fr_acc_d  = fr_inc;
    end

    if (line_end) begin
      byte_cnt_d = '0;
    end else if (hs_q) begin
      if (byte_cnt_q == '1) err_set[2] = 1'b1;
      else                  byte_cnt_d = byte_cnt_q + 1'b1;
    end

    if (pclk_cnt_q == '1) err_set[2] = 1'b1;
    else                  pclk_cnt_d = pclk_cnt_q + 1'b1;

    if (line_end) begin
      if (line_cnt_q == '1) err_set[2] = 1'b1;
      else                  line_cnt_d = line_cnt_q + 1'b1;
      if (line_cnt_q == '0) begin
        first_len_d = byte_cnt_q;
      end else if (byte_cnt_q != first_len_q) begin
        mism_d     = 1'b1;
        err_set[1] = 1'b1;
      end
    end

    // Frame handling reads the post-line values so a line ending in the same
    // cycle is still counted in the frame being published.
    if (fs_q) begin
      if (armed_q) begin
        lines_d       = line_cnt_d;
        line_bytes_d  = first_len_d;
        frame_pclks_d = pclk_cnt_q;
        geom_ok_d     = (line_cnt_d == LINES_EXP) && (first_len_d == BYTES_EXP) && !mism_d;
        stat_valid_d  = 1'b1;
        frame_cnt_d   = frame_cnt_q + 16'd1;
        err_set[0]    = (line_cnt_d != LINES_EXP);
      end
      armed_d     = 1'b1;
      line_cnt_d  = '0;
      first_len_d = '0;
      mism_d      = 1'b0;
      pclk_cnt_d  = CNT_W'(1);
    end

    err_set[3] = hs_q & vs_q;

    if (I_clr) begin
      win_cnt_d   = '0;
      fr_acc_d    = '0;
      fps_d       = fps_q;
      frame_cnt_d = '0;
    end
    // An error raised in the clearing cycle survives the clear
    err_d = (I_clr ? 4'b0000 : err_q) | err_set;
  end

  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_q          <= 1'b0;
      vs_q2         <= 1'b0;
      hs_q          <= 1'b0;
      hs_q2         <= 1'b0;
      fs_q          <= 1'b0;
      hb_cnt_q      <= '0;
      hb_q          <= 1'b0;
      win_cnt_q     <= '0;
      fr_acc_q      <= '0;
      fps_q         <= '0;
      byte_cnt_q    <= '0;
      line_cnt_q    <= '0;
      first_len_q   <= '0;
      mism_q        <= 1'b0;
      pclk_cnt_q    <= '0;
      armed_q       <= 1'b0;
      frame_cnt_q   <= '0;
      lines_q       <= '0;
      line_bytes_q  <= '0;
      frame_pclks_q <= '0;
      geom_ok_q     <= 1'b0;
      stat_valid_q  <= 1'b0;
      err_q         <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      vs_q          <= cmos_vsync;
      vs_q2         <= vs_q;
      hs_q          <= cmos_href;
      hs_q2         <= hs_q;
      fs_q          <= frame_start;
      hb_cnt_q      <= hb_cnt_d;
      hb_q          <= hb_d;
      win_cnt_q     <= win_cnt_d;
      fr_acc_q      <= fr_acc_d;
      fps_q         <= fps_d;
      byte_cnt_q    <= byte_cnt_d;
      line_cnt_q    <= line_cnt_d;
      first_len_q   <= first_len_d;
      mism_q        <= mism_d;
      pclk_cnt_q    <= pclk_cnt_d;
      armed_q       <= armed_d;
      frame_cnt_q   <= frame_cnt_d;
      lines_q       <= lines_d;
      line_bytes_q  <= line_bytes_d;
      frame_pclks_q <= frame_pclks_d;
      geom_ok_q     <= geom_ok_d;
      stat_valid_q  <= stat_valid_d;
      err_q         <= err_d;
    end
  end

  assign O_heartbeat   = hb_q;
  assign O_fps         = fps_q;
  assign O_frame_cnt   = frame_cnt_q;
  assign O_lines       = lines_q;
  assign O_line_bytes  = line_bytes_q;
  assign O_frame_pclks = frame_pclks_q;
  assign O_geom_ok     = geom_ok_q;
  assign O_stat_valid  = stat_valid_q;
  assign O_err         = err_q;

endmodule

// File: tb/tb_cmos_timing_monitor.sv
// Directed bench for cmos_timing_monitor: a 32-bit and an 8-bit counter build
// share stimulus; outputs are sampled 1 time unit after each rising edge.
module tb_cmos_timing_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic        clr = 1'b0;

  logic        hb, geom_ok, stat_valid;
  logic [7:0]  fps;
  logic [15:0] frame_cnt;
  logic [11:0] lines;
  logic [12:0] line_bytes;
  logic [31:0] frame_pclks;
  logic [3:0]  err;

  logic        hb2, geom_ok2, stat_valid2;
  logic [7:0]  fps2;
  logic [15:0] frame_cnt2;
  logic [11:0] lines2;
  logic [12:0] line_bytes2;
  logic [7:0]  frame_pclks2;
  logic [3:0]  err2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmos_timing_monitor #(
    .HALF_PERIOD(50), .CNT_W(32), .LINE_W(12), .BYTE_W(13), .EXP_LINES(4), .EXP_BYTES(8)
  ) u_dut (
    .cmos_pclk(clk), .I_rst_n(rst_n), .cmos_vsync(vsync), .cmos_href(href), .I_clr(clr),
    .O_heartbeat(hb), .O_fps(fps), .O_frame_cnt(frame_cnt), .O_lines(lines),
    .O_line_bytes(line_bytes), .O_frame_pclks(frame_pclks), .O_geom_ok(geom_ok),
    .O_stat_valid(stat_valid), .O_err(err)
  );

  cmos_timing_monitor #(
    .HALF_PERIOD(50), .CNT_W(8), .LINE_W(12), .BYTE_W(13), .EXP_LINES(4), .EXP_BYTES(8)
  ) u_dut8 (
    .cmos_pclk(clk), .I_rst_n(rst_n), .cmos_vsync(vsync), .cmos_href(href), .I_clr(clr),
    .O_heartbeat(hb2), .O_fps(fps2), .O_frame_cnt(frame_cnt2), .O_lines(lines2),
    .O_line_bytes(line_bytes2), .O_frame_pclks(frame_pclks2), .O_geom_ok(geom_ok2),
    .O_stat_valid(stat_valid2), .O_err(err2)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame of `period` cycles: vsync high 3 cycles, then 4 lines of 8 href
  // cycles (line `bad_line` is 7) on a 12-cycle pitch starting at cycle 8.
  // Reports the stat_valid pulse count, the edge of the last pulse and the
  // first edge at which O_err[1] is seen high.
  task automatic send_frame(input int period, input int bad_line,
                            output int sv_cnt, output int sv_at, output int e1_at);
    sv_cnt = 0;
    sv_at  = 0;
    e1_at  = 0;
    for (int t = 0; t < period; t++) begin
      logic h;
      h = 1'b0;
      for (int l = 0; l < 4; l++) begin
        int st, len;
        st  = 8 + 12 * l;
        len = (l == bad_line) ? 7 : 8;
        if (t >= st && t < st + len) h = 1'b1;
      end
      vsync = (t < 3);
      href  = h;
      tick(1);
      if (stat_valid) begin
        sv_cnt++;
        sv_at = t + 1;
      end
      if (err[1] && e1_at == 0) e1_at = t + 1;
    end
  endtask

  initial begin
    int sc, sa, e1;

    // 1: reset state and heartbeat / window timing
    tick(3);
    check("rst_outputs", {hb, fps, frame_cnt, lines, line_bytes, frame_pclks, geom_ok, stat_valid, err}, '0);
    check("rst_outputs8", {hb2, fps2, frame_cnt2, lines2, line_bytes2, frame_pclks2, geom_ok2, stat_valid2, err2}, '0);
    rst_n = 1'b1;
    tick(49);
    check("hb_edge49", hb, 1'b0);
    tick(1);
    check("hb_edge50", hb, 1'b1);
    tick(49);
    check("hb_edge99", hb, 1'b1);
    tick(1);
    check("hb_edge100", hb, 1'b0);
    check("fps_edge100", fps, 8'd0);

    // 2: arming frame then first published frame
    send_frame(200, -1, sc, sa, e1);
    check("arm_no_valid", sc, 0);
    send_frame(200, -1, sc, sa, e1);
    check("pub_valid_cnt", sc, 1);
    check("pub_valid_edge", sa, 3);
    check("pub_lines", lines, 12'd4);
    check("pub_bytes", line_bytes, 13'd8);
    check("pub_pclks", frame_pclks, 32'd200);
    check("pub_geom_ok", geom_ok, 1'b1);
    check("pub_frame_cnt", frame_cnt, 16'd1);
    check("pub_err", err, 4'b0000);

    // 3: short third line, recovery, sticky error and clear
    send_frame(200, 2, sc, sa, e1);
    check("short_err1_edge", e1, 41);
    check("short_err", err, 4'b0010);
    send_frame(200, -1, sc, sa, e1);
    check("bad_geom_ok", geom_ok, 1'b0);
    check("bad_lines", lines, 12'd4);
    check("bad_frame_cnt", frame_cnt, 16'd3);
    send_frame(200, -1, sc, sa, e1);
    check("good_geom_ok", geom_ok, 1'b1);
    check("sticky_err", err, 4'b0010);
    check("good_frame_cnt", frame_cnt, 16'd4);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_err", err, 4'b0000);
    check("clr_frame_cnt", frame_cnt, 16'd0);
    check("clr_keeps_geom", geom_ok, 1'b1);

    // 4: frame every 20 cycles, one start counted on the window-end edge
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(18);
    for (int k = 1; k <= 10; k++) begin
      vsync = 1'b1;
      tick(2);
      if (k == 5 || k == 10) check($sformatf("fps_win%0d", k / 5), fps, 8'd5);
      tick(3);
      vsync = 1'b0;
      tick(15);
    end

    // 5: asynchronous reset during line 2 of frame 3
    send_frame(200, -1, sc, sa, e1);
    send_frame(200, -1, sc, sa, e1);
    send_frame(24, -1, sc, sa, e1);
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {hb, fps, frame_cnt, lines, line_bytes, frame_pclks, geom_ok, stat_valid, err}, '0);
    vsync = 1'b0;
    href  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    send_frame(200, -1, sc, sa, e1);
    check("rearm_no_valid", sc, 0);
    send_frame(200, -1, sc, sa, e1);
    check("rearm_valid_cnt", sc, 1);
    check("rearm_lines", lines, 12'd4);
    check("rearm_bytes", line_bytes, 13'd8);
    check("rearm_pclks", frame_pclks, 32'd200);
    check("rearm_geom_ok", geom_ok, 1'b1);
    check("rearm_frame_cnt", frame_cnt, 16'd1);
    check("rearm_err8", err2, 4'b0000);

    // 6: frame-period saturation on the 8-bit build, then protocol error
    send_frame(300, -1, sc, sa, e1);
    send_frame(200, -1, sc, sa, e1);
    check("sat_pclks8", frame_pclks2, 8'd255);
    check("sat_err8", err2, 4'b0100);
    check("nosat_pclks32", frame_pclks, 32'd300);
    check("nosat_err32", err, 4'b0000);
    vsync = 1'b1;
    href  = 1'b1;
    tick(3);
    check("proto_err32", err, 4'b1000);
    check("proto_err8", err2, 4'b1100);
    vsync = 1'b0;
    href  = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cmos_timing_monitor.md
Name: cmos_timing_monitor

Overview:
Parametrised successor to the single pclk heartbeat counter used for camera bring-up. It runs in the OV5640 pixel-clock domain and provides:
- a configurable heartbeat toggle
- a frames-per-window rate count
- per-frame geometry measurement (lines per frame, bytes per line, pclk cycles per frame), checked against expected values with sticky error flags

Outputs feed PMOD debug pins, LEDs and a future UART status reporter.

Parameters:
HALF_PERIOD, 21_000_000, heartbeat half-period in pclk cycles; the rate window is 2*HALF_PERIOD cycles.
CNT_W, 32, width of the heartbeat, window and frame-period counters.
LINE_W, 12, width of the line counter.
BYTE_W, 13, width of the per-line byte counter.
EXP_LINES, 720, expected href pulses per frame.
EXP_BYTES, 2560, expected href-high cycles per line (1280 px x 2 bytes).

Ports:
cmos_pclk  in  1  camera pixel clock; all logic on rising edge
I_rst_n  in  1  asynchronous active-low reset
cmos_vsync  in  1  camera vsync, active-high
cmos_href  in  1  camera href, active-high data-valid
I_clr  in  1  synchronous clear of error flags, frame counter and rate window
O_heartbeat  out  1  toggles every HALF_PERIOD cycles
O_fps  out  8  frame starts counted in last completed window; saturates at 255
O_frame_cnt  out  16  completed frames since reset/clear; wraps
O_lines  out  LINE_W  lines in last completed frame
O_line_bytes  out  BYTE_W  bytes of first line of last completed frame
O_frame_pclks  out  CNT_W  pclk cycles from previous frame start to current frame start
O_geom_ok  out  1  last completed frame matched EXP_LINES/EXP_BYTES with no line mismatch
O_stat_valid  out  1  one-cycle pulse when geometry outputs update
O_err  out  4  sticky errors: [0] line count != EXP_LINES, [1] line length mismatch, [2] counter saturation, [3] href high while vsync high

Behaviour:
- Reset: cmos_rst_n has the exact name I_rst_n, asynchronous, active-low; clock cmos_pclk. All outputs and internal state go to 0, and the armed flag is cleared.
- Input sampling: cmos_vsync and cmos_href are registered once (vs_q, hs_q), then once more for edge detection (vs_q2, hs_q2).
  - frame_start = vs_q & ~vs_q2
  - line_end = ~hs_q & hs_q2
- Heartbeat: hb_cnt counts 0..HALF_PERIOD-1. At HALF_PERIOD-1, hb_cnt returns to 0 and O_heartbeat inverts. The first toggle to 1 occurs on the HALF_PERIOD-th rising edge after reset release.
- Rate window:
  - win_cnt counts 0..2*HALF_PERIOD-1; fr_acc increments on each frame_start, saturating at 255.
  - At window end, O_fps <= fr_acc (including a frame_start in that same cycle), and fr_acc restarts at 0.
- Byte/line counting:
  - byte_cnt increments every cycle hs_q=1 and resets to 0 on line_end.
  - On line_end, line_cnt increments.
  - On the first line of a frame, first_len <= byte_cnt. On later lines, if byte_cnt != first_len, set mism and O_err[1].
- Frame period: pclk_cnt increments every cycle and restarts at 1 on frame_start.
- frame_start handling, in the cycle after detection:
  - If armed=0: set armed, clear line_cnt/mism/pclk_cnt. No O_stat_valid; outputs unchanged. This is the partial first frame.
  - If armed=1: latch O_lines, O_line_bytes, O_frame_pclks. Set O_geom_ok = (line_cnt==EXP_LINES) & (first_len==EXP_BYTES) & ~mism. Pulse O_stat_valid, increment O_frame_cnt, set O_err[0] if line_cnt != EXP_LINES, then clear per-frame state.
  - Latency: outputs change on the 3rd rising edge after cmos_vsync is first sampled high.
- Saturation: pclk_cnt, byte_cnt and line_cnt hold at all-ones instead of wrapping and set O_err[2].
- Protocol error: hs_q & vs_q sets O_err[3].
- Simultaneous line_end and frame_start: line_end is processed first, so that line is included in the published frame.
- I_clr:
  - Clears O_err, O_frame_cnt, fr_acc and win_cnt.
  - Does not alter armed, geometry outputs, heartbeat or O_fps.
  - If I_clr coincides with an error-set event, the error bit ends at 1.
- Reset mid-frame: everything clears immediately; the next frame is treated as partial.

Test Plan:
1. Params HALF_PERIOD=50. Reset release, idle inputs -> all outputs 0; O_heartbeat rises at edge 50, falls at edge 100; O_fps=0 at edge 100.
2. EXP_LINES=4, EXP_BYTES=8. Frames with 4 lines x 8 href cycles, vsync period 200 cycles -> no O_stat_valid on first vsync. On second: single-cycle pulse, O_lines=4, O_line_bytes=8, O_frame_pclks=200, O_geom_ok=1, O_frame_cnt=1, O_err=0.
3. Third line of a frame 7 cycles -> O_err[1]=1 immediately after that line; next publish O_geom_ok=0. Following good frame gives O_geom_ok=1 while O_err[1] stays 1 until an I_clr pulse, after which O_err=0 and O_frame_cnt=0.
4. HALF_PERIOD=50, frames every 20 cycles, one frame_start aligned to the window-end cycle -> O_fps=5 each window, counted in the closing window.
5. Assert I_rst_n low during line 2 of frame 3 -> outputs 0 asynchronously. After release, first vsync produces no O_stat_valid; the following vsync publishes correct geometry.
6. CNT_W=8, vsync period 300 -> O_frame_pclks=255, O_err[2]=1. href high during vsync high -> O_err[3]=1.
